// File: rtl/shift_sched.sv
// shift_sched: two-requester round-robin scheduler feeding a multi-pass logical-right shifter.
// Each pass shifts by at most MAXSTEP; the result is held until the consumer takes it.
module shift_sched #(
    parameter int WIDTH   = 16,
    parameter int MAXSTEP = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [3:0]       req0_count,
    input  logic [3:0]       req1_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic [7:0]       done_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic ptr, id_r, gnt0, gnt1, accept, last;
    logic [WIDTH-1:0] data_r, shifted;
    logic [3:0] rem;
    logic [2:0] step;
    always_comb begin
        gnt0       = req0_valid && (!req1_valid || !ptr);
        gnt1       = req1_valid && (!req0_valid || ptr);
        req0_ready = state == IDLE && !rst && gnt0;
        req1_ready = state == IDLE && !rst && gnt1;
        accept     = req0_ready || req1_ready;
        last       = rem <= 4'(MAXSTEP);
        step       = last ? rem[2:0] : 3'(MAXSTEP);
        shifted    = data_r >> step;
        out_valid  = state == DONE;
        state_nx   = state;
        if (state == IDLE && accept)
            state_nx = SHIFT;
        else if (state == SHIFT && last)
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            id_r     <= 1'b0;
            data_r   <= '0;
            rem      <= '0;
            out_data <= '0;
            out_id   <= 1'b0;
            done_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                data_r <= gnt0 ? req0_data : req1_data;
                rem    <= gnt0 ? req0_count : req1_count;
                id_r   <= gnt1;
                ptr    <= gnt0;
            end
            if (state == SHIFT) begin
                data_r <= shifted;
                rem    <= rem - {1'b0, step};
                // Result register only changes on the final pass, so it holds across the next job.
                if (last) begin
                    out_data <= shifted;
                    out_id   <= id_r;
                end
            end
            if (out_valid && out_ready)
                done_cnt <= done_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed self-checking bench for shift_sched.
module tb_shift_sched;
    logic clk = 1'b0;
    logic rst, req0_valid, req1_valid, req0_ready, req1_ready, out_valid, out_ready, out_id;
    logic [15:0] req0_data, req1_data, out_data;
    logic [3:0] req0_count, req1_count;
    logic [7:0] done_cnt;
    int total = 0, passed = 0, exp_done = 0;

    always #5 clk = ~clk;

    shift_sched #(.WIDTH(16), .MAXSTEP(7)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_count(req0_count), .req1_count(req1_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .done_cnt(done_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_done = 0;
    endtask

    // Accept cycle is cycle 0; out_valid must first appear in cycle passes+1.
    task automatic job(input bit id, input logic [15:0] d, input logic [3:0] c,
                       input logic [15:0] exp, input int passes);
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_count = c;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_count = c;
        end
        out_ready = 1'b1;
        #1;
        chk("job_grant", {req1_ready, req0_ready}, id ? 2 : 1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 16'h5A5A; req1_data = 16'h5A5A; req0_count = 4'hF; req1_count = 4'hF;
        for (int i = 1; i <= passes; i++) begin
            chk("job_busy_valid", out_valid, 0);
            tick();
        end
        chk("job_out_valid", out_valid, 1);
        chk("job_out_data", out_data, exp);
        chk("job_out_id", out_id, id);
        tick();
        exp_done++;
        chk("job_done_cnt", done_cnt, exp_done[7:0]);
        chk("job_valid_low", out_valid, 0);
        chk("job_data_hold", out_data, exp);
    endtask

    initial begin
        int g_id[$];
        int g_cyc[$];
        int cnt;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b0;
        req0_data = '0; req1_data = '0; req0_count = '0; req1_count = '0;
        tick();
        tick();
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_done_cnt", done_cnt, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        job(1'b0, 16'hB4C3, 4'd3, 16'h1698, 1);
        job(1'b1, 16'hB4C3, 4'd12, 16'h000B, 2);
        job(1'b1, 16'h8000, 4'd15, 16'h0001, 3);
        job(1'b0, 16'h1234, 4'd7, 16'h0024, 1);
        job(1'b1, 16'hFFFF, 4'd8, 16'h00FF, 2);

        // Round-robin with both requesters permanently valid.
        do_reset();
        req0_valid = 1'b1; req0_data = 16'h00F0; req0_count = 4'd4;
        req1_valid = 1'b1; req1_data = 16'h0F00; req1_count = 4'd4;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req0_ready && req1_ready) chk("rr_both_ready", 1, 0);
            if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
            if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
            if (out_valid) chk("rr_out_data", out_data, g_id[$] == 0 ? 16'h000F : 16'h00F0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_grants", g_id.size(), 4);
        if (g_id.size() == 4) begin
            chk("rr_order", {g_id[0][0], g_id[1][0], g_id[2][0], g_id[3][0]}, 4'b0101);
            chk("rr_cycles", {g_cyc[0][7:0], g_cyc[1][7:0], g_cyc[2][7:0], g_cyc[3][7:0]}, 32'h00030609);
        end
        chk("rr_done_cnt", done_cnt, 4);

        // Back-pressure: count 0 result held while out_ready is low.
        req1_valid = 1'b1; req1_data = 16'hFFFF; req1_count = 4'd0; out_ready = 1'b0;
        #1;
        chk("bp_grant", req1_ready, 1);
        tick();
        req1_valid = 1'b0; req1_data = 16'h0000;
        chk("bp_shift_valid", out_valid, 0);
        tick();
        req0_valid = 1'b1; req0_data = 16'h1111; req0_count = 4'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 16'hFFFF);
            chk("bp_hold_id", out_id, 1);
            chk("bp_no_accept", req0_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_consume_no_accept", req0_ready, 0);
        tick();
        chk("bp_idle_ready", req0_ready, 1);
        chk("bp_done_cnt", done_cnt, 5);
        chk("bp_data_hold", out_data, 16'hFFFF);
        req0_valid = 1'b0;
        tick();

        // Reset during second shift pass aborts the job.
        req1_valid = 1'b1; req1_data = 16'hB4C3; req1_count = 4'd12;
        tick();
        req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("abort_rst_ready", {req1_ready, req0_ready}, 0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_valid", out_valid, 0);
            tick();
        end
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_out_data", out_data, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("abort_next_grant", {req1_ready, req0_ready}, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // done_cnt wrap after 256 consumed results.
        do_reset();
        req0_valid = 1'b1; req0_data = 16'h0001; req0_count = 4'd0; out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 255; i++) begin
            if (out_valid && out_ready) cnt++;
            tick();
        end
        chk("wrap_bound_255", cnt, 255);
        chk("wrap_255", done_cnt, 255);
        for (int i = 0; i < 10 && cnt < 256; i++) begin
            if (out_valid && out_ready) cnt++;
            tick();
        end
        chk("wrap_bound_256", cnt, 256);
        chk("wrap_0", done_cnt, 0);
        req0_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
